// File: rtl/div_ratio_sequencer.sv
// Even-ratio clock-enable divider: 50% duty clk_out with ratio 2*cur_half, retuned via valid/ready
// only at period boundaries. Optional period counter under `DIVSEQ_PERIOD_CNT_EN.
module div_ratio_sequencer #(
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned DEFAULT_HALF = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] cur_half
`ifdef DIVSEQ_PERIOD_CNT_EN
  ,
  output logic [15:0]      period_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StPend, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             tick;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cfg_val;
  logic [CNT_W-1:0] pend_sel;

  assign cfg_ready  = (state_q == StIdle) || (state_q == StRun);
  assign busy       = (state_q != StIdle);
  assign xfer       = cfg_valid && cfg_ready;
  assign cfg_val    = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign tick       = (cnt_q == (half_q - CNT_W'(1)));
  assign cnt_inc    = tick ? '0 : (cnt_q + CNT_W'(1));
  // A cfg taken in the same cycle the run stops rides the pending path into IDLE.
  assign pend_sel   = xfer ? cfg_val : pend_q;

  assign cfg_err    = err_q;
  assign clk_out    = clk_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign cur_half   = half_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    clk_d      = clk_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    err_d      = xfer && (cfg_half == '0);

    unique case (state_q)
      StIdle: begin
        clk_d = 1'b0;
        cnt_d = '0;
        if (xfer) begin
          half_d = cfg_val;
        end
        if (en) begin
          state_d = StRun;
        end
      end

      StRun, StPend: begin
        if (!en && !clk_q) begin
          // Low phase: stopping here leaves no high runt, so go straight to IDLE.
          state_d    = StIdle;
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          if (xfer || pend_vld_q) begin
            half_d = pend_sel;
          end
        end else begin
          cnt_d = cnt_inc;
          if (tick) begin
            clk_d  = !clk_q;
            rise_d = !clk_q;
            fall_d = clk_q;
          end
          if (!en) begin
            if (tick) begin
              state_d    = StIdle;
              cnt_d      = '0;
              pend_vld_d = 1'b0;
              if (xfer || pend_vld_q) begin
                half_d = pend_sel;
              end
            end else begin
              state_d    = StDrain;
              pend_d     = pend_sel;
              pend_vld_d = xfer || pend_vld_q;
            end
          end else if (tick && clk_q && pend_vld_q) begin
            state_d    = StRun;
            half_d     = pend_q;
            pend_vld_d = 1'b0;
          end else if (xfer) begin
            state_d    = StPend;
            pend_d     = cfg_val;
            pend_vld_d = 1'b1;
          end
        end
      end

      StDrain: begin
        cnt_d = cnt_inc;
        if (tick) begin
          state_d    = StIdle;
          cnt_d      = '0;
          clk_d      = 1'b0;
          fall_d     = 1'b1;
          pend_vld_d = 1'b0;
          if (pend_vld_q) begin
            half_d = pend_q;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      half_q     <= CNT_W'(DEFAULT_HALF);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      err_q      <= err_d;
    end
  end

`ifdef DIVSEQ_PERIOD_CNT_EN
  logic [15:0] pcnt_q, pcnt_d;

  // Restart the count whenever the active ratio changes.
  always_comb begin
    pcnt_d = pcnt_q;
    if (half_d != half_q) begin
      pcnt_d = '0;
    end else if (fall_d) begin
      pcnt_d = pcnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign period_cnt = pcnt_q;
`endif

endmodule
